fetch_prefetch_queue: RTL

- Fetch stage in front of the decode pipeline register.
- Generates sequential PCs and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents the head to decode.
- Honours decode stalls (hazard unit) and taken-branch redirects from execute by flushing and discarding stale fetches.

---
 rtl/fetch_prefetch_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: issues sequential word fetches over a req/ack handshake and
// buffers {pc, inst} pairs in a small FIFO whose head feeds decode.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        de_valid,
  output logic [31:0] de_inst,
  output logic [31:0] de_pc,
  output logic [31:0] de_pcinc
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             drop_q, drop_d;
  logic             started_q;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];

  logic ack_acc, push, pop;

  // started_q holds the request line low for the first cycle out of reset,
  // so a late ack belonging to a pre-reset request finds nothing to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      started_q  <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
      count_q    <= count_d;
      if (redirect) begin
        rptr_q <= wptr_q;
      end else begin
        if (push) wptr_q <= wptr_q + PTR_ONE;
        if (pop)  rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (imem_req && !imem_ack) state_d = S_WAIT;
      S_WAIT:  if (imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    case (state_q)
      S_IDLE: imem_req = started_q && (count_q < DEPTH_C) && !redirect;
      S_WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign ack_acc = imem_ack && imem_req;
  assign push    = ack_acc && !drop_q && !redirect;
  assign pop     = de_valid && !stall && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    req_addr_d = req_addr_q;
    count_d    = count_q;
    if (state_q == S_IDLE && imem_req) req_addr_d = fetch_pc_q;
    if (redirect) begin
      // A request still in flight must complete; its data is dropped on arrival.
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      drop_d     = (state_q == S_WAIT) && !imem_ack;
      count_d    = '0;
    end else begin
      if (ack_acc) begin
        drop_d = 1'b0;
        if (!drop_q) fetch_pc_d = imem_addr + 32'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    if (push) begin
      pc_mem_q[wptr_q]   <= imem_addr;
      inst_mem_q[wptr_q] <= imem_rdata;
    end
  end

  assign de_valid = (count_q != '0);
  assign de_inst  = de_valid ? inst_mem_q[rptr_q] : NOP_INST;
  assign de_pc    = de_valid ? pc_mem_q[rptr_q] : 32'h0;
  assign de_pcinc = de_valid ? (pc_mem_q[rptr_q] + 32'd4) : 32'h0;

endmodule
